// File: rtl/flash_phy_pkg.sv
// Flash PHY shared types: read buffer entry attributes, partition select,
// the read buffer entry record and its tag compare helper.
// No ports; imported by the read buffer array, its interface and LRU tracker.
package flash_phy_pkg;

  // Storage widths of one read buffer entry.
  localparam int unsigned RdBufAddrW    = 16;
  localparam int unsigned RdBufDataW    = 64;
  localparam int unsigned RdBufInfoSelW = 2;

  typedef enum logic {
    FlashPartData = 1'b0,
    FlashPartInfo = 1'b1
  } flash_part_e;

  typedef enum logic [1:0] {
    Invalid = 2'd0,
    Wip     = 2'd1,
    Valid   = 2'd2
  } rd_buf_attr_e;

  typedef struct packed {
    logic [RdBufAddrW-1:0]    addr;
    flash_part_e              part;
    logic [RdBufInfoSelW-1:0] info_sel;
    logic [RdBufDataW-1:0]    data;
    logic                     err;
    rd_buf_attr_e             attr;
  } rd_buf_t;

  // Full tag compare (address, partition, info select); ignores attr.
  function automatic logic rd_buf_tag_match(input rd_buf_t                  e,
                                            input logic [RdBufAddrW-1:0]    addr,
                                            input logic                     part,
                                            input logic [RdBufInfoSelW-1:0] info_sel);
    return (e.addr == addr) && (logic'(e.part) == part) && (e.info_sel == info_sel);
  endfunction

endpackage

// File: rtl/flash_phy_rd_buf_array_if.sv
// Read buffer array bus: lookup/hit, allocate, fill (update), wipe and the
// per-entry attribute view. slave = the buffer array, master = its user.
// All hit/alloc responses are combinational against the same-cycle request.
interface flash_phy_rd_buf_array_if
  import flash_phy_pkg::*;
#(
  parameter int unsigned NumBuf   = 4,
  parameter int unsigned AddrW    = RdBufAddrW,
  parameter int unsigned DataW    = RdBufDataW,
  parameter int unsigned InfoSelW = RdBufInfoSelW
);
  localparam int unsigned IdxW = $clog2(NumBuf);

  logic                en_i;
  logic                lookup_i;
  logic [AddrW-1:0]    lookup_addr_i;
  logic                lookup_part_i;
  logic [InfoSelW-1:0] lookup_info_sel_i;
  logic                hit_o;
  logic [IdxW-1:0]     hit_idx_o;
  logic                hit_wip_o;
  logic [DataW-1:0]    rd_data_o;
  logic                rd_err_o;
  logic                alloc_i;
  logic                alloc_gnt_o;
  logic [IdxW-1:0]     alloc_idx_o;
  logic                update_i;
  logic [IdxW-1:0]     update_idx_i;
  logic [DataW-1:0]    data_i;
  logic                err_i;
  logic                wipe_i;
  logic [AddrW-1:0]    wipe_addr_i;
  logic                wipe_part_i;
  logic [InfoSelW-1:0] wipe_info_sel_i;
  rd_buf_attr_e [NumBuf-1:0] attr_o;

  modport slave (
    input  en_i, lookup_i, lookup_addr_i, lookup_part_i, lookup_info_sel_i,
    input  alloc_i, update_i, update_idx_i, data_i, err_i,
    input  wipe_i, wipe_addr_i, wipe_part_i, wipe_info_sel_i,
    output hit_o, hit_idx_o, hit_wip_o, rd_data_o, rd_err_o,
    output alloc_gnt_o, alloc_idx_o, attr_o
  );

  modport master (
    output en_i, lookup_i, lookup_addr_i, lookup_part_i, lookup_info_sel_i,
    output alloc_i, update_i, update_idx_i, data_i, err_i,
    output wipe_i, wipe_addr_i, wipe_part_i, wipe_info_sel_i,
    input  hit_o, hit_idx_o, hit_wip_o, rd_data_o, rd_err_o,
    input  alloc_gnt_o, alloc_idx_o, attr_o
  );

endinterface

// File: rtl/flash_phy_rd_buf_lru.sv
// Per-entry age tracking (0 = most recent) and replacement victim choice.
// Ports: touch_i/touch_idx_i mark an entry most recent at the next edge;
// attr_i in, victim_idx_o/victim_vld_o combinational out (no Wip victims).
module flash_phy_rd_buf_lru
  import flash_phy_pkg::*;
#(
  parameter  int unsigned NumBuf = 4,
  localparam int unsigned IdxW   = $clog2(NumBuf)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      touch_i,
  input  logic [IdxW-1:0]           touch_idx_i,
  input  rd_buf_attr_e [NumBuf-1:0] attr_i,
  output logic [IdxW-1:0]           victim_idx_o,
  output logic                      victim_vld_o
);

  // Ages always form a permutation of 0..NumBuf-1, so the oldest Valid
  // entry is unique.
  logic [IdxW-1:0] age_q [NumBuf];
  logic [IdxW-1:0] age_d [NumBuf];

  always_comb begin
    age_d = age_q;
    if (touch_i) begin
      for (int i = 0; i < NumBuf; i++) begin
        if (IdxW'(i) == touch_idx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBuf; i++) age_q[i] <= IdxW'(i);
    end else begin
      age_q <= age_d;
    end
  end

  logic            inv_found, val_found;
  logic [IdxW-1:0] inv_idx, lru_idx, lru_age;

  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    // Descending scan so the lowest Invalid index wins.
    for (int i = NumBuf - 1; i >= 0; i--) begin
      if (attr_i[i] == Invalid) begin
        inv_found = 1'b1;
        inv_idx   = IdxW'(i);
      end
    end
    val_found = 1'b0;
    lru_idx   = '0;
    lru_age   = '0;
    for (int i = 0; i < NumBuf; i++) begin
      if (attr_i[i] == Valid && (!val_found || age_q[i] > lru_age)) begin
        val_found = 1'b1;
        lru_idx   = IdxW'(i);
        lru_age   = age_q[i];
      end
    end
  end

  assign victim_vld_o = inv_found | val_found;
  assign victim_idx_o = inv_found ? inv_idx : lru_idx;

endmodule

// File: rtl/flash_phy_rd_buf_array.sv
// Flash PHY read buffer array: tagged entries (Invalid/Wip/Valid) with
// combinational lookup, LRU allocation, fill via update and wipe by tag.
// Ports: clk_i, rst_ni (async, active-low), bus (slave side of the array bus).
module flash_phy_rd_buf_array
  import flash_phy_pkg::*;
#(
  parameter int unsigned NumBuf   = 4,
  parameter int unsigned AddrW    = RdBufAddrW,
  parameter int unsigned DataW    = RdBufDataW,
  parameter int unsigned InfoSelW = RdBufInfoSelW
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  flash_phy_rd_buf_array_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NumBuf);

  // Entries are stored in the shared package record, so the data/tag widths
  // must equal the package widths.
  if (AddrW != RdBufAddrW || DataW != RdBufDataW || InfoSelW != RdBufInfoSelW ||
      NumBuf < 2 || NumBuf > 16) begin : gen_param_err
    $error("flash_phy_rd_buf_array: unsupported parameter combination");
  end

  rd_buf_t entry_q [NumBuf];
  rd_buf_t entry_d [NumBuf];

  // Lookup
  logic [NumBuf-1:0] hit_vec;
  logic [IdxW-1:0]   hit_idx;
  logic              hit, hit_wip;

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < NumBuf; i++) begin
      hit_vec[i] = bus.lookup_i & bus.en_i & (entry_q[i].attr != Invalid) &
                   rd_buf_tag_match(entry_q[i], bus.lookup_addr_i,
                                    bus.lookup_part_i, bus.lookup_info_sel_i);
    end
    for (int i = NumBuf - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IdxW'(i);
    end
  end

  assign hit     = |hit_vec;
  assign hit_wip = hit & (entry_q[hit_idx].attr == Wip);

  assign bus.hit_o     = hit;
  assign bus.hit_idx_o = hit_idx;
  assign bus.hit_wip_o = hit_wip;
  assign bus.rd_data_o = hit ? entry_q[hit_idx].data : '0;
  assign bus.rd_err_o  = hit & entry_q[hit_idx].err;

  // Allocation and recency
  rd_buf_attr_e [NumBuf-1:0] attr_vec;
  logic [IdxW-1:0] victim_idx;
  logic            victim_vld;
  logic            wipe_same_tag, alloc_gnt, touch;
  logic [IdxW-1:0] touch_idx;

  always_comb begin
    attr_vec = '0;
    for (int i = 0; i < NumBuf; i++) attr_vec[i] = entry_q[i].attr;
  end

  // Refuse to allocate a tag that is being wiped in the same cycle; the
  // new entry would otherwise hold a fill the wiper expects to be gone.
  assign wipe_same_tag = bus.wipe_i &&
                         bus.wipe_addr_i     == bus.lookup_addr_i &&
                         bus.wipe_part_i     == bus.lookup_part_i &&
                         bus.wipe_info_sel_i == bus.lookup_info_sel_i;
  assign alloc_gnt = bus.alloc_i & bus.en_i & victim_vld & ~wipe_same_tag;

  // A grant takes the touch slot; otherwise a hit on a Valid entry does.
  assign touch     = alloc_gnt | (hit & ~hit_wip);
  assign touch_idx = alloc_gnt ? victim_idx : hit_idx;

  assign bus.alloc_gnt_o = alloc_gnt;
  assign bus.alloc_idx_o = victim_idx;
  assign bus.attr_o      = attr_vec;

  flash_phy_rd_buf_lru #(
    .NumBuf (NumBuf)
  ) u_lru (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .touch_i      (touch),
    .touch_idx_i  (touch_idx),
    .attr_i       (attr_vec),
    .victim_idx_o (victim_idx),
    .victim_vld_o (victim_vld)
  );

  // Entry next state. Order matters: update, then wipe (wipe beats a fill
  // on the same entry), then alloc. The victim is never Wip, so it cannot
  // be the update target; an alloc into a victim whose old tag is being
  // wiped still installs the new tag.
  always_comb begin
    for (int i = 0; i < NumBuf; i++) begin
      entry_d[i] = entry_q[i];
      if (!bus.en_i) begin
        entry_d[i].attr = Invalid;
      end else begin
        if (bus.update_i && bus.update_idx_i == IdxW'(i) && entry_q[i].attr == Wip) begin
          entry_d[i].data = bus.data_i;
          entry_d[i].err  = bus.err_i;
          entry_d[i].attr = Valid;
        end
        if (bus.wipe_i && entry_q[i].attr != Invalid &&
            rd_buf_tag_match(entry_q[i], bus.wipe_addr_i, bus.wipe_part_i,
                             bus.wipe_info_sel_i)) begin
          entry_d[i].attr = Invalid;
          entry_d[i].err  = 1'b0;
        end
        if (alloc_gnt && victim_idx == IdxW'(i)) begin
          entry_d[i].addr     = bus.lookup_addr_i;
          entry_d[i].part     = flash_part_e'(bus.lookup_part_i);
          entry_d[i].info_sel = bus.lookup_info_sel_i;
          entry_d[i].err      = 1'b0;
          entry_d[i].attr     = Wip;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBuf; i++) begin
        entry_q[i] <= '{addr: '0, part: FlashPartData, info_sel: '0,
                        data: '0, err: 1'b0, attr: Invalid};
      end
    end else begin
      entry_q <= entry_d;
    end
  end

`ifndef SYNTHESIS
  HitOneHot_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(hit_vec));
  UpdateWip_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.update_i && bus.en_i) |-> (entry_q[bus.update_idx_i].attr == Wip));
  AllocMiss_A: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.alloc_i |-> !hit);
`endif

endmodule

// File: tb/tb_flash_phy_rd_buf_array.sv
module tb_flash_phy_rd_buf_array;
  import flash_phy_pkg::*;

  localparam int NB = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  flash_phy_rd_buf_array_if #(.NumBuf(NB)) bus ();

  flash_phy_rd_buf_array #(.NumBuf(NB)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: entry contents plus a recency list (front = most recent).
  logic [15:0]  m_addr [NB];
  logic         m_part [NB];
  logic [1:0]   m_sel  [NB];
  logic [63:0]  m_data [NB];
  logic         m_err  [NB];
  rd_buf_attr_e m_attr [NB];
  int           m_rec  [$];

  logic        e_hit, e_wip, e_err, e_gnt, e_vvld;
  logic [1:0]  e_idx, e_vidx;
  logic [63:0] e_data;

  function automatic void model_reset();
    m_rec = {};
    for (int i = 0; i < NB; i++) begin
      m_addr[i] = '0; m_part[i] = 1'b0; m_sel[i] = '0;
      m_data[i] = '0; m_err[i]  = 1'b0; m_attr[i] = Invalid;
      m_rec.push_back(i);
    end
  endfunction

  function automatic void model_eval();
    logic ws;
    e_hit = 0; e_idx = 0; e_wip = 0; e_data = 0; e_err = 0;
    if (bus.lookup_i && bus.en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (m_attr[i] != Invalid &&
            {m_addr[i], m_part[i], m_sel[i]} ==
            {bus.lookup_addr_i, bus.lookup_part_i, bus.lookup_info_sel_i}) begin
          e_hit = 1; e_idx = 2'(i); e_wip = (m_attr[i] == Wip);
          e_data = m_data[i]; e_err = m_err[i];
        end
      end
    end
    e_vvld = 0; e_vidx = 0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (m_attr[i] == Invalid) begin e_vvld = 1; e_vidx = 2'(i); end
    end
    if (!e_vvld) begin
      for (int k = m_rec.size() - 1; k >= 0; k--) begin
        if (!e_vvld && m_attr[m_rec[k]] == Valid) begin
          e_vvld = 1; e_vidx = 2'(m_rec[k]);
        end
      end
    end
    ws = bus.wipe_i && ({bus.wipe_addr_i, bus.wipe_part_i, bus.wipe_info_sel_i} ==
                        {bus.lookup_addr_i, bus.lookup_part_i, bus.lookup_info_sel_i});
    e_gnt = bus.alloc_i && bus.en_i && e_vvld && !ws;
  endfunction

  function automatic void m_touch(input int idx);
    for (int k = 0; k < m_rec.size(); k++) begin
      if (m_rec[k] == idx) begin m_rec.delete(k); break; end
    end
    m_rec.push_front(idx);
  endfunction

  function automatic void model_clock();
    rd_buf_attr_e old_attr [NB];
    int u, v;
    model_eval();
    old_attr = m_attr;
    if (!bus.en_i) begin
      for (int i = 0; i < NB; i++) m_attr[i] = Invalid;
    end else begin
      u = int'(bus.update_idx_i);
      if (bus.update_i && old_attr[u] == Wip) begin
        m_data[u] = bus.data_i; m_err[u] = bus.err_i; m_attr[u] = Valid;
      end
      for (int i = 0; i < NB; i++) begin
        if (bus.wipe_i && old_attr[i] != Invalid &&
            {m_addr[i], m_part[i], m_sel[i]} ==
            {bus.wipe_addr_i, bus.wipe_part_i, bus.wipe_info_sel_i}) begin
          m_attr[i] = Invalid; m_err[i] = 1'b0;
        end
      end
      if (e_gnt) begin
        v = int'(e_vidx);
        m_addr[v] = bus.lookup_addr_i; m_part[v] = bus.lookup_part_i;
        m_sel[v] = bus.lookup_info_sel_i; m_err[v] = 1'b0; m_attr[v] = Wip;
      end
    end
    if (e_gnt) m_touch(int'(e_vidx));
    else if (e_hit && !e_wip) m_touch(int'(e_idx));
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic idle();
    bus.en_i = 1'b1; bus.lookup_i = 1'b0; bus.lookup_addr_i = '0;
    bus.lookup_part_i = 1'b0; bus.lookup_info_sel_i = '0; bus.alloc_i = 1'b0;
    bus.update_i = 1'b0; bus.update_idx_i = '0; bus.data_i = '0; bus.err_i = 1'b0;
    bus.wipe_i = 1'b0; bus.wipe_addr_i = '0; bus.wipe_part_i = 1'b0;
    bus.wipe_info_sel_i = '0;
  endtask

  task automatic set_lookup(input logic [15:0] a);
    bus.lookup_i = 1'b1; bus.lookup_addr_i = a;
    bus.lookup_part_i = 1'b0; bus.lookup_info_sel_i = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    set_lookup(16'h0000);
    #12;
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (bus.attr_o[i] !== Invalid) begin
        miscompares++;
        $display("FAIL reset_attr[%0d]: got %0d want %0d", i, bus.attr_o[i], Invalid);
      end
    end
    vectors++;
    if (bus.hit_o !== 1'b0 || bus.rd_data_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_lookup: hit=%b data=%h want hit=0 data=0", bus.hit_o, bus.rd_data_o);
    end
    vectors++;
    if (bus.alloc_idx_o !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_victim: got %0d want 0", bus.alloc_idx_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    idle();
  endtask

  task automatic test_fill_four();
    for (int k = 0; k < NB; k++) begin
      idle();
      set_lookup(16'(16 * (k + 1)));
      bus.alloc_i = 1'b1;
      if (k > 0) begin
        bus.update_i = 1'b1; bus.update_idx_i = 2'(k - 1);
        bus.data_i = 64'(32'h1000 + k - 1);
      end
      #3;
      vectors++;
      if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 2'(k)) begin
        miscompares++;
        $display("FAIL fill_alloc%0d: gnt=%b idx=%0d want gnt=1 idx=%0d",
                 k, bus.alloc_gnt_o, bus.alloc_idx_o, k);
      end
      cyc();
    end
    idle();
    bus.update_i = 1'b1; bus.update_idx_i = 2'd3; bus.data_i = 64'h1003;
    cyc();
    idle();
    #3;
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (bus.attr_o[i] !== Valid) begin
        miscompares++;
        $display("FAIL fill_valid[%0d]: got %0d want %0d", i, bus.attr_o[i], Valid);
      end
    end
    cyc();
  endtask

  task automatic test_lru();
    idle(); set_lookup(16'h10);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b1 || bus.hit_idx_o !== 2'd0 || bus.hit_wip_o !== 1'b0 ||
        bus.rd_data_o !== 64'h1000) begin
      miscompares++;
      $display("FAIL lru_hit10: hit=%b idx=%0d wip=%b data=%h want 1/0/0/1000",
               bus.hit_o, bus.hit_idx_o, bus.hit_wip_o, bus.rd_data_o);
    end
    cyc();
    idle(); set_lookup(16'h50); bus.alloc_i = 1'b1;
    #3;
    vectors++;
    if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 2'd1) begin
      miscompares++;
      $display("FAIL lru_victim: gnt=%b idx=%0d want gnt=1 idx=1", bus.alloc_gnt_o, bus.alloc_idx_o);
    end
    cyc();
    idle(); set_lookup(16'h20);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL lru_evicted: hit=%b want 0", bus.hit_o);
    end
    cyc();
    idle(); set_lookup(16'h50);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b1 || bus.hit_idx_o !== 2'd1 || bus.hit_wip_o !== 1'b1) begin
      miscompares++;
      $display("FAIL lru_new_wip: hit=%b idx=%0d wip=%b want 1/1/1", bus.hit_o, bus.hit_idx_o, bus.hit_wip_o);
    end
    cyc();
  endtask

  task automatic test_alloc_full();
    idle(); bus.en_i = 1'b0; set_lookup(16'h10);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL disabled_hit: hit=%b want 0", bus.hit_o);
    end
    cyc();
    for (int k = 0; k < NB; k++) begin
      idle(); set_lookup(16'(16 * (k + 1))); bus.alloc_i = 1'b1;
      #3;
      vectors++;
      if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 2'(k)) begin
        miscompares++;
        $display("FAIL full_alloc%0d: gnt=%b idx=%0d want gnt=1 idx=%0d",
                 k, bus.alloc_gnt_o, bus.alloc_idx_o, k);
      end
      cyc();
    end
    idle(); set_lookup(16'h50); bus.alloc_i = 1'b1;
    #3;
    vectors++;
    if (bus.alloc_gnt_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_no_gnt: gnt=%b want 0", bus.alloc_gnt_o);
    end
    cyc();
    idle();
    #3;
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (bus.attr_o[i] !== Wip) begin
        miscompares++;
        $display("FAIL full_unchanged[%0d]: got %0d want %0d", i, bus.attr_o[i], Wip);
      end
    end
  endtask

  task automatic test_wipe_update();
    idle();
    bus.update_i = 1'b1; bus.update_idx_i = 2'd2; bus.data_i = 64'hBEEF; bus.err_i = 1'b1;
    bus.wipe_i = 1'b1; bus.wipe_addr_i = 16'h30;
    cyc();
    idle(); set_lookup(16'h30);
    #3;
    vectors++;
    if (bus.attr_o[2] !== Invalid || bus.hit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wipe_beats_update: attr2=%0d hit=%b want attr2=%0d hit=0",
               bus.attr_o[2], bus.hit_o, Invalid);
    end
    bus.alloc_i = 1'b1; bus.wipe_i = 1'b1; bus.wipe_addr_i = 16'h30;
    #1;
    vectors++;
    if (bus.alloc_gnt_o !== 1'b0 || bus.alloc_idx_o !== 2'd2) begin
      miscompares++;
      $display("FAIL wipe_blocks_alloc: gnt=%b idx=%0d want gnt=0 idx=2", bus.alloc_gnt_o, bus.alloc_idx_o);
    end
    cyc();
  endtask

  task automatic test_err_fill();
    idle(); bus.en_i = 1'b0;
    cyc();
    idle(); set_lookup(16'h10); bus.alloc_i = 1'b1;
    #3;
    vectors++;
    if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 2'd0) begin
      miscompares++;
      $display("FAIL err_alloc: gnt=%b idx=%0d want gnt=1 idx=0", bus.alloc_gnt_o, bus.alloc_idx_o);
    end
    cyc();
    idle(); bus.update_i = 1'b1; bus.update_idx_i = 2'd0; bus.data_i = 64'hDEAD; bus.err_i = 1'b1;
    cyc();
    idle(); set_lookup(16'h10);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b1 || bus.hit_idx_o !== 2'd0 || bus.rd_err_o !== 1'b1 ||
        bus.rd_data_o !== 64'hDEAD) begin
      miscompares++;
      $display("FAIL err_hit: hit=%b idx=%0d err=%b data=%h want 1/0/1/dead",
               bus.hit_o, bus.hit_idx_o, bus.rd_err_o, bus.rd_data_o);
    end
    bus.lookup_i = 1'b0;
    #1;
    vectors++;
    if (bus.hit_o !== 1'b0 || bus.rd_data_o !== 64'd0 || bus.rd_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL no_lookup_zero: hit=%b data=%h err=%b want 0/0/0", bus.hit_o, bus.rd_data_o, bus.rd_err_o);
    end
    cyc();
    idle(); set_lookup(16'h10); bus.en_i = 1'b0;
    #3;
    vectors++;
    if (bus.hit_o !== 1'b0 || bus.rd_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL en_low_hit: hit=%b err=%b want 0/0", bus.hit_o, bus.rd_err_o);
    end
    cyc();
    idle(); set_lookup(16'h10);
    #3;
    vectors++;
    if (bus.hit_o !== 1'b0 || bus.attr_o[0] !== Invalid) begin
      miscompares++;
      $display("FAIL en_drop_inval: hit=%b attr0=%0d want 0/%0d", bus.hit_o, bus.attr_o[0], Invalid);
    end
    cyc();
  endtask

  task automatic test_mid_fill_reset();
    idle(); set_lookup(16'h70); bus.alloc_i = 1'b1;
    cyc();
    idle(); set_lookup(16'h70);
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (bus.attr_o[0] !== Invalid || bus.hit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fill_reset: attr0=%0d hit=%b want %0d/0", bus.attr_o[0], bus.hit_o, Invalid);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    idle();
  endtask

  task automatic test_random();
    int wl[$];
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.en_i = ($urandom % 32) != 0;
      bus.lookup_i = ($urandom % 4) != 0;
      bus.lookup_addr_i = 16'(16'h100 + $urandom_range(0, 5));
      bus.lookup_part_i = ($urandom % 4) == 0;
      bus.lookup_info_sel_i = (($urandom % 4) == 0) ? 2'd1 : 2'd0;
      if (($urandom % 8) == 0) begin
        bus.wipe_i = 1'b1;
        if ($urandom % 2) begin
          bus.wipe_addr_i = bus.lookup_addr_i; bus.wipe_part_i = bus.lookup_part_i;
          bus.wipe_info_sel_i = bus.lookup_info_sel_i;
        end else begin
          bus.wipe_addr_i = 16'(16'h100 + $urandom_range(0, 5));
        end
      end
      wl = {};
      for (int i = 0; i < NB; i++) if (m_attr[i] == Wip) wl.push_back(i);
      if (wl.size() > 0 && ($urandom % 2) != 0) begin
        bus.update_i = 1'b1;
        bus.update_idx_i = 2'(wl[$urandom_range(0, wl.size() - 1)]);
        bus.data_i = {$urandom, $urandom};
        bus.err_i = $urandom % 2;
      end
      model_eval();
      if (bus.lookup_i && !e_hit && ($urandom % 2) != 0) bus.alloc_i = 1'b1;
      model_eval();
      #3;
      vectors++;
      if (bus.hit_o !== e_hit || bus.hit_idx_o !== e_idx || bus.hit_wip_o !== e_wip) begin
        miscompares++;
        $display("FAIL rnd_hit@%0d: hit/idx/wip=%b/%0d/%b want %b/%0d/%b",
                 n, bus.hit_o, bus.hit_idx_o, bus.hit_wip_o, e_hit, e_idx, e_wip);
      end
      vectors++;
      if (bus.rd_data_o !== e_data || bus.rd_err_o !== e_err) begin
        miscompares++;
        $display("FAIL rnd_data@%0d: data=%h err=%b want %h/%b", n, bus.rd_data_o, bus.rd_err_o, e_data, e_err);
      end
      vectors++;
      if (bus.alloc_gnt_o !== e_gnt || (e_vvld && bus.alloc_idx_o !== e_vidx)) begin
        miscompares++;
        $display("FAIL rnd_alloc@%0d: gnt=%b idx=%0d want gnt=%b idx=%0d",
                 n, bus.alloc_gnt_o, bus.alloc_idx_o, e_gnt, e_vidx);
      end
      for (int i = 0; i < NB; i++) begin
        vectors++;
        if (bus.attr_o[i] !== m_attr[i]) begin
          miscompares++;
          $display("FAIL rnd_attr@%0d[%0d]: got %0d want %0d", n, i, bus.attr_o[i], m_attr[i]);
        end
      end
      cyc();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_four();
    test_lru();
    test_alloc_full();
    test_wipe_update();
    test_err_fill();
    test_mid_fill_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
